arbiter_rr_8: RTL and testbench

Synchronous 8-requester arbiter that shares one downstream resource among eight clients. Each cycle it either holds the current owner or selects a new one by fixed priority (index 7 highest) or rotating round-robin priority. It outputs a registered one-hot grant, the binary grant index and a valid flag, in the same `out`/`valid` form as the team's 8x3 priority encoders. An optional hold limit forces a release so one client cannot starve the others.

---
 rtl/arbiter_rr_8.sv | 128 ++++++++++++
 tb/tb_arbiter_rr_8.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_rr_8.sv
// Eight-client arbiter with fixed or rotating priority and an optional hold limit.
// All outputs are registered; a new owner is granted on the same edge that releases the old one.
module arbiter_rr_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       fixed_pri,
    output logic [7:0] grant,
    output logic [2:0] out,
    output logic       valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic       HOLD_EN  = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] out_q, out_d;
    logic       valid_q, valid_d;
    logic       preempt_q, preempt_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;

    logic [7:0] owner_mask;
    logic       owner_req;
    logic       others;
    logic       at_limit;
    logic       drop;
    logic       expire;
    logic       arbitrate;
    logic [7:0] arb_req;
    logic [2:0] base;
    logic [2:0] cand;
    logic       arb_found;
    logic [2:0] arb_idx;

    // Release conditions for the current owner; a drop takes precedence over expiry.
    always_comb begin
        owner_mask = 8'b1 << out_q;
        owner_req  = req[out_q];
        others     = |(req & ~owner_mask);
        at_limit   = HOLD_EN && (hold_cnt_q == HOLD_LIM);
        drop       = (state_q == GRANT) && !owner_req;
        expire     = (state_q == GRANT) && owner_req && at_limit && others;
        arbitrate  = (state_q == IDLE) || drop || expire;
        arb_req    = expire ? (req & ~owner_mask) : req;
    end

    // Search order base-1, base-2, ..., base (mod 8); base 0 gives 7 down to 0.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = 3'd0;
        cand      = 3'd0;
        base      = fixed_pri ? 3'd0 : last_q;
        for (int k = 1; k <= 8; k++) begin
            cand = base - 3'(k);
            if (!arb_found && arb_req[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        out_d      = out_q;
        valid_d    = valid_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        if (arbitrate) begin
            preempt_d = expire;
            if (arb_found) begin
                state_d    = GRANT;
                grant_d    = 8'b1 << arb_idx;
                out_d      = arb_idx;
                valid_d    = 1'b1;
                last_d     = arb_idx;
                hold_cnt_d = 8'd1;
            end else begin
                state_d = IDLE;
                grant_d = 8'd0;
                out_d   = 3'd0;
                valid_d = 1'b0;
            end
        end else if (at_limit) begin
            // Limit reached with nobody waiting: start a fresh hold window.
            hold_cnt_d = 8'd1;
        end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 8'd0;
            out_q      <= 3'd0;
            valid_q    <= 1'b0;
            preempt_q  <= 1'b0;
            last_q     <= 3'd0;
            hold_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            preempt_q  <= preempt_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant   = grant_q;
    assign out     = out_q;
    assign valid   = valid_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_arbiter_rr_8.sv
// Bench for arbiter_rr_8: four instances with hold limits 0, 3, 4 and 16 share one stimulus
// stream; a directed vector table, a saturation sequence and random traffic are checked.
module tb_arbiter_rr_8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       fixed_pri;

    logic [7:0] d_grant [4];
    logic [2:0] d_out   [4];
    logic       d_valid [4];
    logic       d_pre   [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    arbiter_rr_8 #(.MAX_HOLD(0)) u_mh0 (
        .clk(clk), .rst(rst), .req(req), .fixed_pri(fixed_pri),
        .grant(d_grant[0]), .out(d_out[0]), .valid(d_valid[0]), .preempt(d_pre[0]));
    arbiter_rr_8 #(.MAX_HOLD(3)) u_mh3 (
        .clk(clk), .rst(rst), .req(req), .fixed_pri(fixed_pri),
        .grant(d_grant[1]), .out(d_out[1]), .valid(d_valid[1]), .preempt(d_pre[1]));
    arbiter_rr_8 #(.MAX_HOLD(4)) u_mh4 (
        .clk(clk), .rst(rst), .req(req), .fixed_pri(fixed_pri),
        .grant(d_grant[2]), .out(d_out[2]), .valid(d_valid[2]), .preempt(d_pre[2]));
    arbiter_rr_8 #(.MAX_HOLD(16)) u_mh16 (
        .clk(clk), .rst(rst), .req(req), .fixed_pri(fixed_pri),
        .grant(d_grant[3]), .out(d_out[3]), .valid(d_valid[3]), .preempt(d_pre[3]));

    // Reference model: owner as an integer, search order built by modular arithmetic.
    int mh_tab  [4] = '{0, 3, 4, 16};
    bit m_busy  [4];
    int m_owner [4];
    int m_last  [4];
    int m_hold  [4];
    bit m_pre   [4];

    function automatic int pick(logic [7:0] r, logic fp, int last);
        int idx;
        for (int k = 1; k <= 8; k++) begin
            idx = fp ? (8 - k) : ((last - k + 16) % 8);
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input int k, input logic r_rst, input logic [7:0] r_req, input logic r_fp);
        bit         arb;
        logic [7:0] r;
        logic [7:0] rest;
        int         w;
        if (r_rst) begin
            m_busy[k] = 0; m_owner[k] = 0; m_last[k] = 0; m_hold[k] = 0; m_pre[k] = 0;
            return;
        end
        m_pre[k] = 0;
        arb = !m_busy[k];
        r   = r_req;
        if (m_busy[k]) begin
            rest = r_req;
            rest[m_owner[k]] = 1'b0;
            if (!r_req[m_owner[k]]) begin
                arb = 1;
            end else if (mh_tab[k] != 0 && m_hold[k] == mh_tab[k] && rest != 8'd0) begin
                arb = 1; r = rest; m_pre[k] = 1;
            end else if (mh_tab[k] != 0 && m_hold[k] == mh_tab[k]) begin
                m_hold[k] = 1;
            end else if (m_hold[k] < 255) begin
                m_hold[k] = m_hold[k] + 1;
            end
        end
        if (arb) begin
            w = pick(r, r_fp, m_last[k]);
            if (w >= 0) begin
                m_busy[k] = 1; m_owner[k] = w; m_last[k] = w; m_hold[k] = 1;
            end else begin
                m_busy[k] = 0; m_owner[k] = 0;
            end
        end
    endtask

    function automatic logic [12:0] pack_exp(logic vld, int idx, logic pre);
        logic [7:0] g;
        logic [2:0] o;
        g = vld ? (8'b1 << idx) : 8'd0;
        o = vld ? 3'(idx) : 3'd0;
        return {g, o, vld, pre};
    endfunction

    function automatic logic [12:0] pack_dut(int k);
        return {d_grant[k], d_out[k], d_valid[k], d_pre[k]};
    endfunction

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t: got grant=%h out=%0d valid=%b preempt=%b, expected grant=%h out=%0d valid=%b preempt=%b",
                     name, $time, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit after the edge.
    task automatic step(input logic r_rst, input logic [7:0] r_req, input logic r_fp);
        rst = r_rst; req = r_req; fixed_pri = r_fp;
        @(posedge clk);
        for (int k = 0; k < 4; k++) model_step(k, r_rst, r_req, r_fp);
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("model_mh%0d", mh_tab[k]), pack_dut(k), pack_exp(m_busy[k], m_owner[k], m_pre[k]));
    endtask

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       fp;
        int         sel;
        int         eout;
        logic       evalid;
        logic       epre;
        string      name;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [7:0] q, input logic fp, input int sel,
                       input int eo, input logic ev, input logic ep, input string nm);
        vec_t v;
        v.rst = r; v.req = q; v.fp = fp; v.sel = sel;
        v.eout = eo; v.evalid = ev; v.epre = ep; v.name = nm;
        tbl.push_back(v);
    endtask

    logic [7:0] rq;
    logic       rfp;
    logic       rrst;

    initial begin
        rst = 1'b1; req = 8'd0; fixed_pri = 1'b0;

        // Reset and fixed priority, limit 16.
        add(1, 8'h00, 0, 3, 0, 0, 0, "reset");
        add(0, 8'h2C, 1, 3, 5, 1, 0, "fixed_first");
        add(0, 8'h0C, 1, 3, 3, 1, 0, "fixed_drop5");
        add(0, 8'h04, 1, 3, 2, 1, 0, "fixed_drop3");
        add(0, 8'h00, 1, 3, 0, 0, 0, "fixed_idle");
        add(0, 8'h10, 0, 3, 4, 1, 0, "rr_from_last2");
        add(1, 8'h10, 0, 3, 0, 0, 0, "reset_midgrant");
        add(0, 8'h81, 0, 3, 7, 1, 0, "rr_after_reset");
        // Round-robin fairness, unlimited hold.
        add(1, 8'h00, 0, 0, 0, 0, 0, "reset");
        add(0, 8'hFF, 0, 0, 7, 1, 0, "rr_start");
        for (int i = 7; i >= 0; i--)
            add(0, 8'hFF & ~(8'b1 << i), 0, 0, (i + 7) % 8, 1, 0, "rr_rotate");
        // Expiry with a competitor, limit 4.
        add(1, 8'h00, 0, 2, 0, 0, 0, "reset");
        add(0, 8'h04, 0, 2, 2, 1, 0, "exp_hold1");
        for (int i = 0; i < 3; i++)
            add(0, 8'h44, 0, 2, 2, 1, 0, "exp_hold");
        add(0, 8'h44, 0, 2, 6, 1, 1, "exp_preempt");
        add(0, 8'h44, 0, 2, 6, 1, 0, "exp_after");
        // Expiry without a competitor, limit 4.
        add(1, 8'h00, 0, 2, 0, 0, 0, "reset");
        for (int i = 0; i < 12; i++)
            add(0, 8'h02, 0, 2, 1, 1, 0, "solo_hold");
        // Drop and expiry on the same edge, limit 3.
        add(1, 8'h00, 0, 1, 0, 0, 0, "reset");
        add(0, 8'h10, 0, 1, 4, 1, 0, "sim_hold1");
        add(0, 8'h11, 0, 1, 4, 1, 0, "sim_hold2");
        add(0, 8'h11, 0, 1, 4, 1, 0, "sim_hold3");
        add(0, 8'h01, 0, 1, 0, 1, 0, "sim_drop_wins");
        // Priority mode change mid-ownership, limit 16.
        add(1, 8'h00, 0, 3, 0, 0, 0, "reset");
        add(0, 8'h01, 0, 3, 0, 1, 0, "fp_owner0");
        add(0, 8'h81, 1, 3, 0, 1, 0, "fp_toggle_hold");
        add(0, 8'h81, 0, 3, 0, 1, 0, "fp_toggle_hold");
        add(0, 8'h81, 1, 3, 0, 1, 0, "fp_toggle_hold");
        add(0, 8'h80, 1, 3, 7, 1, 0, "fp_next_arb");

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].fp);
            check(tbl[i].name, pack_dut(tbl[i].sel), pack_exp(tbl[i].evalid, tbl[i].eout, tbl[i].epre));
        end

        // Long contested hold: unlimited owner never yields, the counter must saturate quietly.
        step(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h81, 1'b1);
            check("saturate_hold", pack_dut(0), pack_exp(1'b1, 7, 1'b0));
        end

        // Random traffic: fast-changing then slow-changing requests.
        rq = 8'd0; rfp = 1'b0;
        step(1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range((i < 1000) ? 5 : 29) == 0) rq[b] = ~rq[b];
            if ($urandom_range(15) == 0) rfp = ~rfp;
            rrst = ($urandom_range(199) == 0);
            step(rrst, rq, rfp);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
